// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART transmit scheduler: baud codes and FSM encodings.
// The baud generator understands only these four codes.
package uart_tx_scheduler_pkg;

  localparam logic [1:0] BAUD24  = 2'b00;
  localparam logic [1:0] BAUD48  = 2'b01;
  localparam logic [1:0] BAUD96  = 2'b10;
  localparam logic [1:0] BAUD192 = 2'b11;

  localparam logic [1:0] SCH_IDLE   = 2'd0;
  localparam logic [1:0] SCH_CFG    = 2'd1;
  localparam logic [1:0] SCH_LAUNCH = 2'd2;
  localparam logic [1:0] SCH_WAIT   = 2'd3;

  typedef logic [1:0] baud_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module uart_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  // Scan from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin : pick
    int j;
    j       = 0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j[IDX_W-1:0]]) begin
        gnt_idx = j[IDX_W-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Time-shares one baud generator + UART transmitter among NUM_REQ requesters,
// reprogramming the baud rate (with a settle delay) when the winner needs another rate.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int    NUM_REQ      = 4,
  parameter int    DATA_W       = 8,
  parameter int    SETTLE_CYC   = 16,
  parameter baud_t DEFAULT_BAUD = BAUD96,
  localparam int   IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_baud,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [1:0]                baud_rate,
  output logic                      baud_restart,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_send,
  input  logic                      tx_done,
  output logic                      sched_busy,
  output logic [IDX_W-1:0]          grant_id
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SETTLE_CYC);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gid_q, gid_d;
  logic [DATA_W-1:0] data_q, data_d;
  baud_t             hbaud_q, hbaud_d;
  baud_t             baud_q, baud_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  baud_t              win_baud;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign win_baud = req_baud[int'(gnt_idx)*2 +: 2];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    hbaud_d = hbaud_q;
    baud_d  = baud_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCH_IDLE: begin
        cnt_d = '0;
        if (gnt_vld) begin
          data_d  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
          hbaud_d = win_baud;
          gid_d   = gnt_idx;
          ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          state_d = (win_baud != baud_q) ? SCH_CFG : SCH_LAUNCH;
        end
      end
      SCH_CFG: begin
        if (cnt_q == '0) baud_d = hbaud_q;
        if (cnt_q < CNT_SAT) cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CNT_LAST) state_d = SCH_LAUNCH;
      end
      SCH_LAUNCH: state_d = SCH_WAIT;
      SCH_WAIT:   if (tx_done) state_d = SCH_IDLE;
      default:    state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCH_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      hbaud_q <= DEFAULT_BAUD;
      baud_q  <= DEFAULT_BAUD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      hbaud_q <= hbaud_d;
      baud_q  <= baud_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses are gated by reset so an aborting cycle never acks or launches.
  assign req_ack      = (state_q == SCH_IDLE && !reset) ? gnt : '0;
  assign baud_restart = (state_q == SCH_CFG) && (cnt_q == '0) && !reset;
  assign tx_send      = (state_q == SCH_LAUNCH) && !reset;
  assign tx_data      = data_q;
  assign baud_rate    = baud_q;
  assign sched_busy   = (state_q != SCH_IDLE);
  assign grant_id     = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler; stimulus pushes expectations, a monitor pops them.
module tb_uart_tx_scheduler;
  import uart_tx_scheduler_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int SC = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*2-1:0]  req_baud = '0;
  logic [NR-1:0] req_ack;
  logic [1:0]    baud_rate;
  logic          baud_restart;
  logic [DW-1:0] tx_data;
  logic          tx_send;
  logic          tx_done = 1'b0;
  logic          sched_busy;
  logic [1:0]    grant_id;

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .SETTLE_CYC(SC), .DEFAULT_BAUD(BAUD96)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_baud(req_baud), .req_ack(req_ack), .baud_rate(baud_rate),
    .baud_restart(baud_restart), .tx_data(tx_data), .tx_send(tx_send),
    .tx_done(tx_done), .sched_busy(sched_busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] baud;
    int         id;
    int         lat;
    int         gap;
  } tx_exp_t;

  int      ack_q[$];
  int      rst_q[$];
  tx_exp_t tx_q[$];
  int      checks = 0;
  int      errors = 0;
  int      last_ack = 0;
  int      last_tx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [7:0] d, input logic [1:0] b);
    req_data[idx*DW +: DW] = d;
    req_baud[idx*2 +: 2]   = b;
  endtask

  task automatic push_tx(input logic [7:0] d, input logic [1:0] b, input int id, input int lat, input int gap);
    tx_exp_t t;
    t.data = d; t.baud = b; t.id = id; t.lat = lat; t.gap = gap;
    tx_q.push_back(t);
  endtask

  task automatic wait_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (req_ack != '0) seen = 1'b1;
    end
    chk("wait_ack_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_tx();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (tx_send) seen = 1'b1;
    end
    chk("wait_tx_timeout", {31'd0, seen}, 32'd1);
  endtask

  // Answer a launch with tx_done three cycles later; optionally drop all requests then.
  task automatic finish_frame(input bit drop);
    wait_tx();
    tick(3);
    if (drop) req_valid = '0;
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  initial begin
    fork
      begin : stim
        tick(3);
        reset = 1'b0;
        chk("rst_ack", req_ack, 0);
        chk("rst_baud_rate", baud_rate, BAUD96);
        chk("rst_restart", baud_restart, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_busy", sched_busy, 0);
        chk("rst_grant_id", grant_id, 0);

        // Same-rate byte: no reprogramming.
        set_req(0, 8'hA5, BAUD96);
        ack_q.push_back(0);
        push_tx(8'hA5, BAUD96, 0, 1, 0);
        req_valid = 4'b0001;
        wait_ack();
        tick(1);
        req_valid = '0;
        finish_frame(1'b0);
        tick(2);

        // Rate change: restart pulse then SETTLE_CYC settle cycles.
        set_req(0, 8'h3C, BAUD192);
        ack_q.push_back(0);
        rst_q.push_back(1);
        push_tx(8'h3C, BAUD192, 0, SC + 1, 0);
        req_valid = 4'b0001;
        wait_ack();
        tick(1);
        req_valid = '0;
        finish_frame(1'b0);
        tick(2);

        // Stray tx_done in CFG and in the LAUNCH cycle must not end the frame.
        set_req(1, 8'h5A, BAUD48);
        ack_q.push_back(1);
        rst_q.push_back(1);
        push_tx(8'h5A, BAUD48, 1, SC + 1, 0);
        req_valid = 4'b0010;
        wait_ack();
        tick(1);
        req_valid = '0;
        tick(4);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(11);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(3);
        chk("busy_after_stray_done", sched_busy, 1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("idle_after_real_done", sched_busy, 0);
        tick(2);

        // Pointer sits at 2: requests 0 and 1 wrap around.
        set_req(0, 8'hC0, BAUD48);
        set_req(1, 8'hC1, BAUD48);
        ack_q.push_back(0);
        ack_q.push_back(1);
        push_tx(8'hC0, BAUD48, 0, 1, 0);
        push_tx(8'hC1, BAUD48, 1, 1, 5);
        req_valid = 4'b0011;
        finish_frame(1'b0);
        finish_frame(1'b1);
        tick(2);

        // Reset two cycles into CFG; req3 stays pending and is served again.
        set_req(3, 8'h77, BAUD192);
        ack_q.push_back(3);
        rst_q.push_back(1);
        req_valid = 4'b1000;
        wait_ack();
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("abort_ack", req_ack, 0);
        chk("abort_baud_rate", baud_rate, BAUD96);
        chk("abort_restart", baud_restart, 0);
        chk("abort_tx_data", tx_data, 0);
        chk("abort_tx_send", tx_send, 0);
        chk("abort_busy", sched_busy, 0);
        chk("abort_grant_id", grant_id, 0);
        ack_q.push_back(3);
        rst_q.push_back(1);
        push_tx(8'h77, BAUD192, 3, SC + 1, 0);
        tick(1);
        reset = 1'b0;
        wait_ack();
        tick(1);
        req_valid = '0;
        finish_frame(1'b0);
        tick(2);

        // All four held: fair rotation 0,1,2,3,0 with one IDLE cycle between frames.
        set_req(0, 8'h11, BAUD192);
        set_req(1, 8'h22, BAUD192);
        set_req(2, 8'h33, BAUD192);
        set_req(3, 8'h44, BAUD192);
        for (int i = 0; i < 5; i++) ack_q.push_back(i % 4);
        push_tx(8'h11, BAUD192, 0, 1, 0);
        push_tx(8'h22, BAUD192, 1, 1, 5);
        push_tx(8'h33, BAUD192, 2, 1, 5);
        push_tx(8'h44, BAUD192, 3, 1, 5);
        push_tx(8'h11, BAUD192, 0, 1, 5);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) finish_frame(i == 4);
        tick(4);
        set_req(2, 8'h00, BAUD24);

        chk("ack_q_drained", ack_q.size(), 0);
        chk("restart_q_drained", rst_q.size(), 0);
        chk("tx_q_drained", tx_q.size(), 0);
      end
      begin : mon
        forever begin
          @(negedge clock);
          if (req_ack != '0) begin
            if (ack_q.size() == 0) chk("ack_unexpected", req_ack, 0);
            else chk("ack_onehot", req_ack, 32'd1 << ack_q.pop_front());
            last_ack = cyc;
          end
          if (baud_restart) begin
            if (rst_q.size() == 0) chk("restart_unexpected", baud_restart, 0);
            else chk("restart_latency", cyc - last_ack, rst_q.pop_front());
          end
          if (tx_send) begin
            if (tx_q.size() == 0) chk("tx_send_unexpected", tx_send, 0);
            else begin
              tx_exp_t t;
              t = tx_q.pop_front();
              chk("tx_data", tx_data, t.data);
              chk("tx_baud_rate", baud_rate, t.baud);
              chk("tx_grant_id", grant_id, t.id);
              chk("tx_latency", cyc - last_ack, t.lat);
              if (t.gap != 0) chk("tx_gap", cyc - last_tx, t.gap);
            end
            last_tx = cyc;
          end
        end
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
